// File: rtl/cpc_audio_mixer_pkg.sv
// Shared definitions for the CPC audio mixer: pan bit positions, FSM states,
// config word width and the derived-width helpers.
package cpc_audio_pkg;

   localparam int unsigned PAN_L = 0;
   localparam int unsigned PAN_R = 1;
   localparam int unsigned CFG_W = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } mix_state_t;

   // Accumulator width: DW+4 bit products plus headroom for NCH channels + EAR + MIC.
   function automatic int unsigned mix_aw(input int unsigned nch, input int unsigned dw);
      return dw + 4 + $clog2(nch + 2);
   endfunction

   function automatic int unsigned mix_sw(input int unsigned nch);
      return (nch > 2) ? $clog2(nch) : 1;
   endfunction

endpackage

// File: rtl/cpc_audio_mixer_if.sv
// Configuration write bus from the core's I/O decode into the mixer.
interface cpc_audio_mixer_if
   import cpc_audio_pkg::*;
#(
   parameter int unsigned SW = 2
);

   logic             cfg_we;
   logic [SW-1:0]    cfg_sel;
   logic [CFG_W-1:0] cfg_data;

   modport master (output cfg_we, cfg_sel, cfg_data);
   modport slave  (input  cfg_we, cfg_sel, cfg_data);

endinterface

// File: rtl/cpc_audio_mixer_sigma_delta.sv
// First-order sigma-delta 1-bit DAC; the carry out of the accumulator is the bitstream.
module sigma_delta_dac #(
   parameter int unsigned W = 15
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] pcm,
   output logic         dout
);

   logic [W:0] s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s <= '0;
      end else begin
         s <= {1'b0, s[W-1:0]} + {1'b0, pcm};
      end
   end

   assign dout = s[W];

endmodule

// File: rtl/cpc_audio_mixer.sv
// NCH-channel PSG + EAR/MIC stereo mixer with per-channel gain/pan registers,
// one source accumulated per cycle, and a sigma-delta DAC per side.
module cpc_audio_mixer
   import cpc_audio_pkg::*;
#(
   parameter int unsigned        NCH      = 3,
   parameter int unsigned        DW       = 8,
   parameter int unsigned        EAR_LVL  = 1024,
   parameter int unsigned        MIC_LVL  = 512,
   parameter logic [2*NCH-1:0]   RST_PAN  = (2*NCH)'(6'b10_11_01),
   parameter logic [3:0]         RST_GAIN = 4'd15,
   localparam int unsigned       AW       = mix_aw(NCH, DW),
   localparam int unsigned       SW       = mix_sw(NCH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sample_stb,
   input  logic [NCH*DW-1:0]     ch_data,
   input  logic                  ear,
   input  logic                  mic,
   cpc_audio_mixer_if.slave      cfg,
   output logic [AW-1:0]         pcm_left,
   output logic [AW-1:0]         pcm_right,
   output logic                  pcm_valid,
   output logic                  overrun,
   output logic                  audio_out_left,
   output logic                  audio_out_right
);

   localparam int unsigned IW = $clog2(NCH + 2);

   mix_state_t     state, state_nxt;
   logic [IW-1:0]  idx;
   logic           ear_meta, ear_sync;
   logic [SW-1:0]  sel;

   logic [3:0]     gain_q    [NCH];
   logic [1:0]     pan_q     [NCH];
   logic [DW-1:0]  ch_snap   [NCH];
   logic [3:0]     gain_snap [NCH];
   logic [1:0]     pan_snap  [NCH];
   logic           ear_snap, mic_snap;

   logic [AW-1:0]  acc_l, acc_r, add_l, add_r;
   logic [DW+3:0]  term;
   logic           start, done, stb_in_acc;

   assign sel = cfg.cfg_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ear_meta <= 1'b0;
         ear_sync <= 1'b0;
      end else begin
         ear_meta <= ear;
         ear_sync <= ear_meta;
      end
   end

   // Out-of-range selects simply match no channel and are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            gain_q[i] <= RST_GAIN;
            pan_q[i]  <= RST_PAN[2*i +: 2];
         end
      end else if (cfg.cfg_we) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            if (32'(sel) == i) begin
               {pan_q[i], gain_q[i]} <= cfg.cfg_data;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      start      = 1'b0;
      done       = 1'b0;
      stb_in_acc = 1'b0;
      add_l      = '0;
      add_r      = '0;
      term       = '0;
      case (state)
         ST_IDLE: begin
            if (sample_stb) begin
               start     = 1'b1;
               state_nxt = ST_ACC;
            end
         end
         ST_ACC: begin
            stb_in_acc = sample_stb;
            for (int unsigned i = 0; i < NCH; i++) begin
               if (32'(idx) == i) begin
                  term = (DW+4)'(ch_snap[i]) * (DW+4)'(gain_snap[i]);
                  if (pan_snap[i][PAN_L]) add_l = AW'(term);
                  if (pan_snap[i][PAN_R]) add_r = AW'(term);
               end
            end
            if (32'(idx) == NCH && ear_snap) begin
               add_l = AW'(EAR_LVL);
               add_r = AW'(EAR_LVL);
            end
            if (32'(idx) == NCH + 1) begin
               if (mic_snap) begin
                  add_l = AW'(MIC_LVL);
                  add_r = AW'(MIC_LVL);
               end
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done = 1'b1;
            if (sample_stb) begin
               start     = 1'b1;
               state_nxt = ST_ACC;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            ch_snap[i]   <= '0;
            gain_snap[i] <= '0;
            pan_snap[i]  <= '0;
         end
         ear_snap <= 1'b0;
         mic_snap <= 1'b0;
         acc_l    <= '0;
         acc_r    <= '0;
         idx      <= '0;
      end else if (start) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            ch_snap[i]   <= ch_data[i*DW +: DW];
            gain_snap[i] <= gain_q[i];
            pan_snap[i]  <= pan_q[i];
         end
         ear_snap <= ear_sync;
         mic_snap <= mic;
         acc_l    <= '0;
         acc_r    <= '0;
         idx      <= '0;
      end else if (state == ST_ACC) begin
         acc_l <= acc_l + add_l;
         acc_r <= acc_r + add_r;
         idx   <= idx + IW'(1);
      end
   end

   // DONE publishes the finished sums even when a new sweep clears them on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcm_left  <= '0;
         pcm_right <= '0;
         pcm_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         pcm_valid <= done;
         if (done) begin
            pcm_left  <= acc_l;
            pcm_right <= acc_r;
         end
         if (stb_in_acc) overrun <= 1'b1;
      end
   end

   sigma_delta_dac #(.W(AW)) u_dac_left (
      .clk   (clk),
      .rst_n (rst_n),
      .pcm   (pcm_left),
      .dout  (audio_out_left)
   );

   sigma_delta_dac #(.W(AW)) u_dac_right (
      .clk   (clk),
      .rst_n (rst_n),
      .pcm   (pcm_right),
      .dout  (audio_out_right)
   );

endmodule
